// File: rtl/dbg_spi_master.sv
// Host-side SPI mode-0 master for the FPGA debug port: runs the flash-read
// transaction (command, 3 address bytes, status polling, data fetch), one SS frame per byte.
module dbg_spi_master #(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 16,
    parameter int POLL_LIMIT = 64
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req,
    input  logic [23:0] addr,
    output logic        busy,
    output logic        done,
    output logic [7:0]  data,
    output logic [1:0]  err_code,
    output logic        spi_sclk,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic        spi_ss
);

    localparam int CNT_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        E_IDLE, E_SETUP, E_SHIFT, E_HOLD, E_GAP
    } eng_e;

    typedef enum logic [3:0] {
        S_IDLE, S_CMD, S_A2, S_A1, S_A0, S_P0, S_POLL, S_FETCH, S_DONE, S_ERR
    } seq_e;

    eng_e          eng_q, eng_d;
    seq_e          seq_q, seq_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic          high_q, high_d;
    logic [7:0]    tx_q, tx_d;
    logic [7:0]    rx_q, rx_d;
    logic          miso_s1_q, miso_s2_q;
    logic [23:0]   addr_q, addr_d;
    logic [7:0]    poll_q, poll_d;
    logic [7:0]    data_q, data_d;
    logic [1:0]    err_q, err_d;

    logic          div_end;
    logic          frame_end;
    logic          frame_start;
    logic [7:0]    tx_next;

    assign div_end   = (cnt_q == CW'(CLK_DIV - 1));
    assign frame_end = (eng_q == E_GAP) && (cnt_q == CW'(GAP_CYCLES - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            eng_q     <= E_IDLE;
            seq_q     <= S_IDLE;
            cnt_q     <= '0;
            bit_q     <= 3'd0;
            high_q    <= 1'b0;
            tx_q      <= 8'h00;
            rx_q      <= 8'h00;
            miso_s1_q <= 1'b0;
            miso_s2_q <= 1'b0;
            addr_q    <= 24'h000000;
            poll_q    <= 8'd0;
            data_q    <= 8'h00;
            err_q     <= 2'd0;
        end else begin
            eng_q     <= eng_d;
            seq_q     <= seq_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            high_q    <= high_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            miso_s1_q <= spi_miso;
            miso_s2_q <= miso_s1_q;
            addr_q    <= addr_d;
            poll_q    <= poll_d;
            data_q    <= data_d;
            err_q     <= err_d;
        end
    end

    // Sequencer decisions are taken on the last GAP cycle, so a frame always completes first.
    always_comb begin
        seq_d  = seq_q;
        addr_d = addr_q;
        poll_d = poll_q;
        data_d = data_q;
        err_d  = err_q;
        case (seq_q)
            S_IDLE: begin
                if (req) begin
                    seq_d  = S_CMD;
                    addr_d = addr;
                    poll_d = 8'd0;
                end
            end
            S_DONE, S_ERR: seq_d = S_IDLE;
            default: begin
                if (frame_end) begin
                    case (seq_q)
                        S_CMD: seq_d = S_A2;
                        S_A2: begin
                            if (rx_q == 8'h03) seq_d = S_A1;
                            else begin seq_d = S_ERR; err_d = 2'd1; end
                        end
                        S_A1: begin
                            if (rx_q == 8'h02) seq_d = S_A0;
                            else begin seq_d = S_ERR; err_d = 2'd1; end
                        end
                        S_A0: begin
                            if (rx_q == 8'h01) seq_d = S_P0;
                            else begin seq_d = S_ERR; err_d = 2'd1; end
                        end
                        S_P0: begin
                            if (rx_q == 8'h00) seq_d = S_POLL;
                            else begin seq_d = S_ERR; err_d = 2'd1; end
                        end
                        S_POLL: begin
                            if (rx_q == 8'hFE) begin
                                if (poll_q + 8'd1 == 8'(POLL_LIMIT)) begin
                                    seq_d = S_ERR;
                                    err_d = 2'd2;
                                end else begin
                                    poll_d = poll_q + 8'd1;
                                end
                            end else if (rx_q == 8'hFF) begin
                                seq_d = S_FETCH;
                            end else begin
                                seq_d = S_ERR;
                                err_d = 2'd3;
                            end
                        end
                        S_FETCH: begin
                            seq_d  = S_DONE;
                            data_d = rx_q;
                            err_d  = 2'd0;
                        end
                        default: ;
                    endcase
                end
            end
        endcase
    end

    always_comb begin
        frame_start = 1'b0;
        if ((seq_q == S_IDLE && req) || frame_end) begin
            frame_start = seq_d inside {S_CMD, S_A2, S_A1, S_A0, S_P0, S_POLL, S_FETCH};
        end
        case (seq_d)
            S_CMD:   tx_next = 8'h01;
            S_A2:    tx_next = addr_q[23:16];
            S_A1:    tx_next = addr_q[15:8];
            S_A0:    tx_next = addr_q[7:0];
            default: tx_next = 8'h00;
        endcase
    end

    // MISO is captured at the end of each SCLK high half so the 2-flop synchronizer
    // delay still lands on the value present at the rising edge.
    always_comb begin
        eng_d  = eng_q;
        cnt_d  = cnt_q;
        bit_d  = bit_q;
        high_d = high_q;
        tx_d   = tx_q;
        rx_d   = rx_q;
        case (eng_q)
            E_IDLE: begin
                if (frame_start) begin
                    eng_d = E_SETUP;
                    cnt_d = '0;
                    tx_d  = tx_next;
                end
            end
            E_SETUP: begin
                if (div_end) begin
                    eng_d  = E_SHIFT;
                    cnt_d  = '0;
                    bit_d  = 3'd0;
                    high_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            E_SHIFT: begin
                if (!div_end) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    cnt_d = '0;
                    if (!high_q) begin
                        high_d = 1'b1;
                    end else begin
                        high_d = 1'b0;
                        rx_d   = {rx_q[6:0], miso_s2_q};
                        tx_d   = {tx_q[6:0], 1'b0};
                        if (bit_q == 3'd7) eng_d = E_HOLD;
                        else               bit_d = bit_q + 3'd1;
                    end
                end
            end
            E_HOLD: begin
                if (div_end) begin
                    eng_d = E_GAP;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            E_GAP: begin
                if (frame_end) begin
                    cnt_d = '0;
                    if (frame_start) begin
                        eng_d = E_SETUP;
                        tx_d  = tx_next;
                    end else begin
                        eng_d = E_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: eng_d = E_IDLE;
        endcase
    end

    always_comb begin
        spi_ss   = !(eng_q inside {E_SETUP, E_SHIFT, E_HOLD});
        spi_sclk = (eng_q == E_SHIFT) && high_q;
        spi_mosi = (eng_q == E_SETUP || eng_q == E_SHIFT) ? tx_q[7] : 1'b0;
        busy     = (seq_q != S_IDLE);
        done     = (seq_q == S_DONE) || (seq_q == S_ERR);
        data     = data_q;
        err_code = err_q;
    end

endmodule

// File: tb/tb_dbg_spi_master.sv
// Bench for dbg_spi_master: a negedge-sampled slave model replays per-frame reply
// bytes and logs MOSI bytes, SCLK period, MOSI stability and frame spacing.
`timescale 1ns/1ps
module tb_dbg_spi_master;

    localparam int CLK_DIV      = 2;
    localparam int GAP          = 16;
    localparam int POLL_LIMIT   = 4;
    localparam int FRAME_CYCLES = 18 * CLK_DIV + GAP;

    logic        clk;
    logic        resetn;
    logic        req;
    logic [23:0] addr;
    logic        busy;
    logic        done;
    logic [7:0]  data;
    logic [1:0]  errCode;
    logic        spiSclk;
    logic        spiMosi;
    logic        spiMiso = 1'b0;
    logic        spiSs;

    int checkCount = 0;
    int errorCount = 0;

    logic [7:0] replyQ[$];
    logic [7:0] expMosi[$];
    logic [7:0] mosiLog[$];
    int         riseLog[$];

    int         cyc = 0;
    int         frameCount = 0;
    int         riseCount = 0;
    int         lastRiseCyc = 0;
    int         lastStartCyc = 0;
    int         lastPeriod = 0;
    int         lastFrameLen = 0;
    int         periodErr = 0;
    int         stableErr = 0;
    int         frameLenErr = 0;
    logic [7:0] curReply = 8'h00;
    logic [7:0] mosiByte = 8'h00;
    logic       prevSs = 1'b1;
    logic       prevSclk = 1'b0;
    logic       lowMosi = 1'b0;

    bit         sawDone;
    logic [7:0] doneData;
    logic [1:0] doneErr;
    logic       busyAtDone;
    logic       busyAfter;
    logic       doneAfter;

    dbg_spi_master #(
        .CLK_DIV   (CLK_DIV),
        .GAP_CYCLES(GAP),
        .POLL_LIMIT(POLL_LIMIT)
    ) dut (
        .clk     (clk),
        .resetn  (resetn),
        .req     (req),
        .addr    (addr),
        .busy    (busy),
        .done    (done),
        .data    (data),
        .err_code(errCode),
        .spi_sclk(spiSclk),
        .spi_mosi(spiMosi),
        .spi_miso(spiMiso),
        .spi_ss  (spiSs)
    );

    // 100 MHz system clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave model: loads the next reply byte on SS fall, shifts MISO after each SCLK fall,
    // captures MOSI at each rise and tracks SCLK/frame timing.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (!spiSs && prevSs) begin
            frameCount = frameCount + 1;
            if (frameCount > 1) begin
                lastFrameLen = cyc - lastStartCyc;
                if (lastFrameLen != FRAME_CYCLES) frameLenErr = frameLenErr + 1;
            end
            lastStartCyc = cyc;
            curReply = 8'h00;
            if (replyQ.size() > 0) curReply = replyQ.pop_front();
            spiMiso   = curReply[7];
            mosiByte  = 8'h00;
            riseCount = 0;
            lowMosi   = spiMosi;
        end else if (!spiSs) begin
            if (spiSclk) begin
                if (spiMosi !== lowMosi) stableErr = stableErr + 1;
                if (!prevSclk) begin
                    riseCount = riseCount + 1;
                    mosiByte  = {mosiByte[6:0], spiMosi};
                    if (riseCount > 1) begin
                        lastPeriod = cyc - lastRiseCyc;
                        if (lastPeriod != 2 * CLK_DIV) periodErr = periodErr + 1;
                    end
                    lastRiseCyc = cyc;
                end
            end else begin
                if (prevSclk) begin
                    curReply = {curReply[6:0], 1'b0};
                    spiMiso  = curReply[7];
                end
                lowMosi = spiMosi;
            end
        end else if (!prevSs) begin
            mosiLog.push_back(mosiByte);
            riseLog.push_back(riseCount);
            spiMiso = 1'b0;
        end
        prevSs   = spiSs;
        prevSclk = spiSclk;
    end

    // Single comparison point: counts every check and reports any mismatch
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount = checkCount + 1;
        if (observed !== expected) begin
            errorCount = errorCount + 1;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Issues one read request; holdReq leaves req high after the accept
    task automatic applyStimulus(input logic [23:0] a, input bit holdReq);
        mosiLog.delete();
        riseLog.delete();
        frameCount = 0;
        @(negedge clk);
        addr = a;
        req  = 1'b1;
        @(negedge clk);
        if (!holdReq) req = 1'b0;
        checkOutput("busyAccept", busy, 1);
    endtask

    // Waits (bounded) for the done pulse, then samples busy/done one cycle later
    task automatic waitDone();
        sawDone = 1'b0;
        for (int i = 0; i < 2000 && !sawDone; i++) begin
            @(negedge clk);
            if (done) begin
                sawDone    = 1'b1;
                doneData   = data;
                doneErr    = errCode;
                busyAtDone = busy;
            end
        end
        checkOutput("doneSeen", sawDone, 1);
        @(negedge clk);
        busyAfter = busy;
        doneAfter = done;
    endtask

    task automatic checkFrames(input string name);
        checkOutput({name, " frames"}, frameCount, expMosi.size());
        for (int i = 0; i < expMosi.size(); i++) begin
            if (i < mosiLog.size())
                checkOutput($sformatf("%s mosi[%0d]", name, i), mosiLog[i], expMosi[i]);
        end
    endtask

    task automatic checkResult(input string name, input logic [7:0] expData, input logic [1:0] expErr);
        checkOutput({name, " data"}, doneData, expData);
        checkOutput({name, " err"}, doneErr, expErr);
        checkOutput({name, " busyAtDone"}, busyAtDone, 1);
        checkOutput({name, " busyAfter"}, busyAfter, 0);
        checkOutput({name, " doneAfter"}, doneAfter, 0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int badRises;
        resetn = 1'b1;
        req    = 1'b0;
        addr   = 24'h000000;
        #2 resetn = 1'b0;
        #1;
        checkOutput("rst ss", spiSs, 1);
        checkOutput("rst sclk", spiSclk, 0);
        checkOutput("rst mosi", spiMosi, 0);
        checkOutput("rst busy", busy, 0);
        checkOutput("rst done", done, 0);
        checkOutput("rst data", data, 8'h00);
        checkOutput("rst err", errCode, 2'd0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] test 1: two busy polls, byte 0xA5");
        replyQ  = '{8'h00, 8'h03, 8'h02, 8'h01, 8'h00, 8'hFE, 8'hFE, 8'hFF, 8'hA5};
        expMosi = '{8'h01, 8'h12, 8'h34, 8'h56, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        applyStimulus(24'h123456, 1'b0);
        waitDone();
        checkResult("t1", 8'hA5, 2'd0);
        checkFrames("t1");

        $display("[TB] test 2: ready on first poll, req held through done");
        replyQ  = '{8'h00, 8'h03, 8'h02, 8'h01, 8'h00, 8'hFF, 8'h3C};
        expMosi = '{8'h01, 8'h00, 8'hFF, 8'h80, 8'h00, 8'h00, 8'h00};
        applyStimulus(24'h00FF80, 1'b1);
        waitDone();
        req = 1'b0;
        checkResult("t2", 8'h3C, 2'd0);
        @(negedge clk);
        checkOutput("t2 busyIdle", busy, 0);
        checkFrames("t2");

        $display("[TB] test 3: echo mismatch in A1");
        replyQ  = '{8'h00, 8'h03, 8'h07};
        expMosi = '{8'h01, 8'hAB, 8'hCD};
        applyStimulus(24'hABCDEF, 1'b0);
        waitDone();
        checkResult("t3", 8'h3C, 2'd1);
        repeat (80) @(negedge clk);
        checkFrames("t3");

        $display("[TB] test 4: poll timeout");
        replyQ  = '{8'h00, 8'h03, 8'h02, 8'h01, 8'h00, 8'hFE, 8'hFE, 8'hFE, 8'hFE, 8'hFE, 8'hFE};
        expMosi = '{8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        applyStimulus(24'h000001, 1'b0);
        waitDone();
        checkResult("t4", 8'h3C, 2'd2);
        repeat (80) @(negedge clk);
        checkFrames("t4");

        $display("[TB] test 4b: bad poll reply after one busy poll");
        replyQ  = '{8'h00, 8'h03, 8'h02, 8'h01, 8'h00, 8'hFE, 8'h55};
        expMosi = '{8'h01, 8'h65, 8'h43, 8'h21, 8'h00, 8'h00, 8'h00};
        applyStimulus(24'h654321, 1'b0);
        waitDone();
        checkResult("t4b", 8'h3C, 2'd3);
        checkFrames("t4b");

        $display("[TB] test 4c: echo mismatch in P0");
        replyQ  = '{8'h00, 8'h03, 8'h02, 8'h01, 8'h09};
        expMosi = '{8'h01, 8'h11, 8'h22, 8'h33, 8'h00};
        applyStimulus(24'h112233, 1'b0);
        waitDone();
        checkResult("t4c", 8'h3C, 2'd1);
        checkFrames("t4c");

        $display("[TB] test 5: reset in the middle of the A0 frame");
        replyQ = '{8'h00, 8'h03, 8'h02, 8'h01, 8'h00, 8'hFF, 8'h99};
        applyStimulus(24'h0A0B0C, 1'b0);
        for (int i = 0; i < 1000 && frameCount < 4; i++) @(negedge clk);
        checkOutput("t5 reachA0", frameCount, 4);
        repeat (12) @(negedge clk);
        checkOutput("t5 midFrameSs", spiSs, 0);
        #2 resetn = 1'b0;
        #1;
        checkOutput("t5 ss", spiSs, 1);
        checkOutput("t5 sclk", spiSclk, 0);
        checkOutput("t5 busy", busy, 0);
        checkOutput("t5 mosi", spiMosi, 0);
        checkOutput("t5 data", data, 8'h00);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (3) @(negedge clk);

        replyQ  = '{8'h00, 8'h03, 8'h02, 8'h01, 8'h00, 8'hFF, 8'h5A};
        expMosi = '{8'h01, 8'hFE, 8'hDC, 8'hBA, 8'h00, 8'h00, 8'h00};
        applyStimulus(24'hFEDCBA, 1'b0);
        waitDone();
        checkResult("t5b", 8'h5A, 2'd0);
        checkFrames("t5b");

        $display("[TB] test 6: SCLK timing with CLK_DIV=2");
        badRises = 0;
        foreach (riseLog[i]) if (riseLog[i] != 8) badRises = badRises + 1;
        checkOutput("t6 risesPerFrame", badRises, 0);
        checkOutput("t6 frameLogSize", riseLog.size(), 7);
        checkOutput("t6 sclkPeriod", lastPeriod, 2 * CLK_DIV);
        checkOutput("t6 periodErr", periodErr, 0);
        checkOutput("t6 mosiStable", stableErr, 0);
        checkOutput("t6 frameLen", lastFrameLen, FRAME_CYCLES);
        checkOutput("t6 frameLenErr", frameLenErr, 0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
